// File: rtl/sort_engine.sv
// -----------------------------------------------------------------------------
// sort_engine
//   Handshaked, tag-carrying iterative sorter. A vector of N keys, each paired
//   with a tag, is loaded on accept and sorted by N odd-even transposition
//   phases, one phase per clock. The order (ascending or descending) is chosen
//   per vector. Equal keys never swap, so the sort is stable. The number of
//   swaps is accumulated and equals the inversion count of the input vector.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   input vector valid
//   in_ready   block can accept a vector (registered, from state)
//   in_desc    1 = descending, 0 = ascending; sampled on accept
//   in_data    N keys, lane k = [k*DW +: DW]
//   in_tag     N tags, lane k = [k*TW +: TW]
//   out_valid  sorted vector valid (registered, from state)
//   out_ready  consumer accepts result
//   out_data   sorted keys, lane 0 first in the selected order
//   out_tag    tags permuted together with their keys
//   out_swaps  number of compare-exchanges that swapped
// -----------------------------------------------------------------------------
module sort_engine #(
  parameter int N  = 6,
  parameter int DW = 8,
  parameter int TW = 3,
  parameter int SW = $clog2(N*(N-1)/2+1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_desc,
  input  logic [N*DW-1:0] in_data,
  input  logic [N*TW-1:0] in_tag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N*DW-1:0] out_data,
  output logic [N*TW-1:0] out_tag,
  output logic [SW-1:0]   out_swaps
);

  localparam int PW = $clog2(N);
  localparam logic [PW-1:0] LAST_PHASE = PW'(N-1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SORT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q;
  logic [DW-1:0]   key_q   [N];
  logic [TW-1:0]   tag_q   [N];
  logic            desc_q;
  logic [PW-1:0]   phase_q;
  logic [SW-1:0]   swaps_q;

  logic [DW-1:0]   key_nxt [N];
  logic [TW-1:0]   tag_nxt [N];
  logic [SW-1:0]   phase_swaps;
  logic [SW-1:0]   swaps_nxt;

  // Swap decision for the pair (a, b) where a sits in the lower lane.
  // Strict comparisons keep tied keys in their input order.
  function automatic logic need_swap(input logic [DW-1:0] a,
                                     input logic [DW-1:0] b,
                                     input logic          desc);
    if (desc)
      return a < b;
    else
      return a > b;
  endfunction

  // One transposition phase. Pairs start at lanes whose parity matches the
  // phase parity, so pairs never overlap and end lanes without a partner hold.
  always_comb begin
    phase_swaps = '0;
    for (int k = 0; k < N; k++) begin
      key_nxt[k] = key_q[k];
      tag_nxt[k] = tag_q[k];
    end
    for (int i = 0; i < N - 1; i++) begin
      if (i[0] == phase_q[0]) begin
        if (need_swap(key_q[i], key_q[i+1], desc_q)) begin
          key_nxt[i]   = key_q[i+1];
          key_nxt[i+1] = key_q[i];
          tag_nxt[i]   = tag_q[i+1];
          tag_nxt[i+1] = tag_q[i];
          phase_swaps  = phase_swaps + SW'(1);
        end
      end
    end
  end

  // Total swaps cannot exceed N*(N-1)/2, which SW is sized to hold.
  assign swaps_nxt = swaps_q + phase_swaps;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_tag   <= '0;
      out_swaps <= '0;
      desc_q    <= 1'b0;
      phase_q   <= '0;
      swaps_q   <= '0;
      for (int k = 0; k < N; k++) begin
        key_q[k] <= '0;
        tag_q[k] <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready) begin
            for (int k = 0; k < N; k++) begin
              key_q[k] <= in_data[k*DW +: DW];
              tag_q[k] <= in_tag[k*TW +: TW];
            end
            desc_q   <= in_desc;
            phase_q  <= '0;
            swaps_q  <= '0;
            in_ready <= 1'b0;
            state_q  <= SORT;
          end else begin
            // First cycle after reset release raises in_ready here.
            in_ready <= 1'b1;
          end
        end

        SORT: begin
          for (int k = 0; k < N; k++) begin
            key_q[k] <= key_nxt[k];
            tag_q[k] <= tag_nxt[k];
          end
          swaps_q <= swaps_nxt;
          if (phase_q == LAST_PHASE) begin
            // Final phase result goes straight to the output registers.
            for (int k = 0; k < N; k++) begin
              out_data[k*DW +: DW] <= key_nxt[k];
              out_tag[k*TW +: TW]  <= tag_nxt[k];
            end
            out_swaps <= swaps_nxt;
            out_valid <= 1'b1;
            phase_q   <= '0;
            state_q   <= DONE;
          end else begin
            phase_q <= phase_q + PW'(1);
          end
        end

        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_q   <= IDLE;
          end
        end

        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sort_engine.sv
module tb_sort_engine;

  localparam int N  = 6;
  localparam int DW = 8;
  localparam int TW = 3;
  localparam int SW = 4;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic            in_desc;
  logic [N*DW-1:0] in_data;
  logic [N*TW-1:0] in_tag;
  logic            out_valid;
  logic            out_ready;
  logic [N*DW-1:0] out_data;
  logic [N*TW-1:0] out_tag;
  logic [SW-1:0]   out_swaps;

  sort_engine #(.N(N), .DW(DW), .TW(TW), .SW(SW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_desc   (in_desc),
    .in_data   (in_data),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag),
    .out_swaps (out_swaps)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Current stimulus vector and reference results
  logic [DW-1:0] mk [N];
  logic [TW-1:0] mt [N];
  logic          md;
  logic [N*DW-1:0] exp_data;
  logic [N*TW-1:0] exp_tag;
  int              exp_inv;
  int              acc_cyc;

  // Reference: stable insertion sort plus pairwise inversion count.
  task automatic ref_model();
    logic [DW-1:0] k [N];
    logic [TW-1:0] t [N];
    logic [DW-1:0] tk;
    logic [TW-1:0] tt;
    int j;
    exp_inv = 0;
    for (int a = 0; a < N; a++)
      for (int b = a + 1; b < N; b++)
        if (md ? (mk[a] < mk[b]) : (mk[a] > mk[b])) exp_inv++;
    for (int a = 0; a < N; a++) begin
      k[a] = mk[a];
      t[a] = mt[a];
    end
    for (int a = 1; a < N; a++) begin
      j = a;
      while (j > 0 && (md ? (k[j] > k[j-1]) : (k[j] < k[j-1]))) begin
        tk = k[j]; k[j] = k[j-1]; k[j-1] = tk;
        tt = t[j]; t[j] = t[j-1]; t[j-1] = tt;
        j--;
      end
    end
    for (int a = 0; a < N; a++) begin
      exp_data[a*DW +: DW] = k[a];
      exp_tag[a*TW +: TW]  = t[a];
    end
  endtask

  task automatic drive_vec();
    for (int a = 0; a < N; a++) begin
      in_data[a*DW +: DW] = mk[a];
      in_tag[a*TW +: TW]  = mt[a];
    end
    in_desc = md;
  endtask

  task automatic set_vec(input int k0, input int k1, input int k2, input int k3,
                         input int k4, input int k5, input logic d);
    mk[0] = DW'(k0); mk[1] = DW'(k1); mk[2] = DW'(k2);
    mk[3] = DW'(k3); mk[4] = DW'(k4); mk[5] = DW'(k5);
    for (int a = 0; a < N; a++) mt[a] = TW'(a);
    md = d;
  endtask

  task automatic rand_vec(input int maxk);
    for (int a = 0; a < N; a++) begin
      mk[a] = DW'($urandom_range(0, maxk));
      mt[a] = TW'($urandom_range(0, 7));
    end
    md = 1'($urandom_range(0, 1));
  endtask

  // Wait for in_ready at a negedge, present the vector, accept on next edge.
  task automatic accept_vec(input bit keep_valid);
    int n = 0;
    while (!in_ready && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("ready_timeout", 64'(in_ready), 64'd1);
    drive_vec();
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    acc_cyc = cyc;
    if (!keep_valid) in_valid = 1'b0;
  endtask

  // Count negedges from accept until out_valid; expect exactly N.
  task automatic wait_done();
    int lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("latency", 64'(lat), 64'(N));
  endtask

  task automatic check_model(input string name);
    ref_model();
    check({name, "_data"}, 64'(out_data), 64'(exp_data));
    check({name, "_tag"}, 64'(out_tag), 64'(exp_tag));
    check({name, "_swaps"}, 64'(out_swaps), 64'(exp_inv));
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("post_hs_valid", 64'(out_valid), 64'd0);
    check("post_hs_ready", 64'(in_ready), 64'd1);
  endtask

  logic [N*DW-1:0] held_data;
  logic [N*TW-1:0] held_tag;
  logic [SW-1:0]   held_swaps;
  int              prev_acc;

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_desc = 1'b0;
    in_data = '0;
    in_tag = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_swaps", 64'(out_swaps), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_in_ready", 64'(in_ready), 64'd1);

    // Descending directed vector
    set_vec(3, 9, 1, 9, 5, 0, 1'b1);
    accept_vec(0);
    wait_done();
    check("desc_data", 64'(out_data), 64'({8'd0, 8'd1, 8'd3, 8'd5, 8'd9, 8'd9}));
    check("desc_tag", 64'(out_tag), 64'({3'd5, 3'd2, 3'd0, 3'd4, 3'd3, 3'd1}));
    check("desc_swaps", 64'(out_swaps), 64'd5);
    release_out();

    // Ascending, same vector: tied 9s keep tag 1 before 3
    set_vec(3, 9, 1, 9, 5, 0, 1'b0);
    accept_vec(0);
    wait_done();
    check("asc_data", 64'(out_data), 64'({8'd9, 8'd9, 8'd5, 8'd3, 8'd1, 8'd0}));
    check("asc_tag", 64'(out_tag), 64'({3'd3, 3'd1, 3'd4, 3'd0, 3'd2, 3'd5}));
    check("asc_swaps", 64'(out_swaps), 64'd9);
    release_out();

    // Already sorted descending
    set_vec(255, 200, 100, 50, 2, 1, 1'b1);
    accept_vec(0);
    wait_done();
    check("sorted_data", 64'(out_data), 64'({8'd1, 8'd2, 8'd50, 8'd100, 8'd200, 8'd255}));
    check("sorted_swaps", 64'(out_swaps), 64'd0);
    release_out();

    // Fully reversed: maximum swap count, no wrap
    set_vec(1, 2, 3, 4, 5, 6, 1'b1);
    accept_vec(0);
    wait_done();
    check("rev_data", 64'(out_data), 64'({8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6}));
    check("rev_tag", 64'(out_tag), 64'({3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5}));
    check("rev_swaps", 64'(out_swaps), 64'd15);

    // Backpressure: hold DONE five cycles while a new vector is offered
    held_data = out_data;
    held_tag = out_tag;
    held_swaps = out_swaps;
    set_vec(7, 7, 7, 7, 7, 7, 1'b0);
    drive_vec();
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_valid", 64'(out_valid), 64'd1);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_data", 64'(out_data), 64'(held_data));
      check("bp_tag", 64'(out_tag), 64'(held_tag));
      check("bp_swaps", 64'(out_swaps), 64'(held_swaps));
    end
    in_valid = 1'b0;
    release_out();
    repeat (N + 2) @(negedge clk);
    check("bp_no_accept", 64'(out_valid), 64'd0);
    check("bp_idle_ready", 64'(in_ready), 64'd1);

    // Reset during phase 3 (phase p executes at accept edge + p + 1)
    set_vec(10, 40, 20, 50, 30, 60, 1'b1);
    accept_vec(0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mrst_valid", 64'(out_valid), 64'd0);
    check("mrst_data", 64'(out_data), 64'd0);
    check("mrst_tag", 64'(out_tag), 64'd0);
    check("mrst_swaps", 64'(out_swaps), 64'd0);
    check("mrst_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    check("mrst_ready_up", 64'(in_ready), 64'd1);
    check("mrst_no_out", 64'(out_valid), 64'd0);
    rand_vec(7);
    accept_vec(0);
    wait_done();
    check_model("after_rst");
    release_out();

    // Back-to-back: in_valid and out_ready held high, 4 random vectors
    out_ready = 1'b1;
    prev_acc = 0;
    for (int v = 0; v < 4; v++) begin
      rand_vec((v % 2 == 0) ? 7 : 255);
      accept_vec(1);
      if (v > 0) check("b2b_interval", 64'(acc_cyc - prev_acc), 64'(N + 2));
      prev_acc = acc_cyc;
      wait_done();
      check_model("b2b");
      if (v == 3) in_valid = 1'b0;
      @(negedge clk);
    end
    out_ready = 1'b0;

    // Extra random single vectors with heavy ties
    for (int v = 0; v < 6; v++) begin
      rand_vec(3);
      accept_vec(0);
      wait_done();
      check_model("rand");
      release_out();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sort_engine.md
# sort_engine

Parametrised, handshaked tag-carrying sorter that generalises the fixed 6-lane sorter in the scoring datapath. It accepts one vector of N keys, each with a companion tag, and sorts them iteratively with one odd-even transposition phase per cycle. The result is ascending or descending, selected per vector, and stable. It also reports the number of swaps performed, which equals the inversion count of the input. It sits between the score generator and the selection logic, and valid/ready on both sides lets either neighbour stall it.

## Interface
- N, 6: lane count, ≥ 2
- DW, 8: key width in bits
- TW, 3: tag width in bits
- SW, $clog2(N*(N-1)/2+1): swap-count width (4 for N=6)

- clk  in  1  rising-edge clock
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  input vector valid
- in_ready  out  1  block can accept a vector
- in_desc  in  1  sort order for this vector: 1 = descending, 0 = ascending; sampled on accept
- in_data  in  N*DW  keys; lane k = [k*DW +: DW]
- in_tag  in  N*TW  tags; lane k = [k*TW +: TW]
- out_valid  out  1  sorted vector valid
- out_ready  in  1  consumer accepts result
- out_data  out  N*DW  sorted keys; lane 0 is first in the selected order
- out_tag  out  N*TW  tags permuted together with their keys
- out_swaps  out  SW  number of compare-exchanges that swapped

## Operation
- FSM has three states: IDLE, SORT, DONE.
- IDLE
  - in_ready = 1.
  - On in_valid && in_ready: load the key/tag registers, latch in_desc, clear the swap counter and phase counter, and go to SORT.
- SORT (lasts N cycles)
  - Phase p runs on cycle p, for p = 0..N-1.
  - Even p compares lanes (0,1), (2,3), …
  - Odd p compares lanes (1,2), (3,4), …
  - A lane left unpaired (odd N, or the end lanes) holds its value.
  - Swap rule:
    - Descending: swap iff lane[i] < lane[i+1].
    - Ascending: swap iff lane[i] > lane[i+1].
  - Equal keys never swap, so the sort is stable: tied keys keep their input lane order.
  - Each swap moves key and tag together.
  - The swap counter adds the number of swaps in each phase; it is SW bits wide and never overflows.
  - After phase N-1 completes, go to DONE.
- DONE
  - out_valid = 1.
  - out_data, out_tag and out_swaps are held constant until out_ready.
  - On out_valid && out_ready, go to IDLE.
  - Output registers keep their last value after leaving DONE.
- in_ready = 0 in SORT and DONE. in_valid and in_data are ignored there.
- Comparisons are unsigned DW-bit.

## Timing
- Reset: on a clk edge with rst_n = 0, from any state (including mid-SORT and DONE), the block goes to IDLE. The following are cleared to 0:
  - out_valid
  - out_data, out_tag, out_swaps
  - internal key/tag registers, phase counter, swap counter
- An in-flight vector is discarded on reset and never appears at the output.
- in_ready is 0 while rst_n = 0, and 1 from the first edge after rst_n goes high.
- Latency:
  - Accept at edge E.
  - Phases execute at edges E+1 … E+N.
  - out_valid is high from edge E+N.
- Throughput: next accept at E+N+2 at the earliest (output handshake at E+N+1, IDLE for one cycle). This is one vector per N+2 cycles.
- Backpressure: out_ready low holds DONE indefinitely with all outputs stable and in_ready = 0.
- in_desc changes after accept have no effect on the vector in flight.
- All outputs are registered. in_ready and out_valid are decoded directly from state registers, with no combinational path from any input.

## Test plan
- Descending: N=6, in_data lanes [3,9,1,9,5,0], tags [0,1,2,3,4,5], in_desc=1.
  - out_data [9,9,5,3,1,0]; out_tag [1,3,4,0,2,5]; out_swaps 5.
  - out_valid rises exactly 6 cycles after accept.
- Ascending: same vector, in_desc=0.
  - out_data [0,1,3,5,9,9]; out_tag [5,2,0,4,1,3]; out_swaps 9.
  - Tied 9s keep tag order 1 before 3.
- Extremes, both with in_desc=1:
  - Already sorted [255,200,100,50,2,1]: output identical, out_swaps 0.
  - Reversed [1,2,3,4,5,6]: out [6,5,4,3,2,1], out_swaps 15 (maximum value, no wrap).
- Backpressure: hold out_ready=0 for 5 cycles after out_valid.
  - Outputs stable and in_ready=0 throughout.
  - A new in_valid vector is not accepted.
  - When out_ready goes to 1: handshake, then IDLE one cycle later with in_ready=1.
- Reset mid-sort: drive rst_n=0 for one edge during phase 3.
  - Next cycle: IDLE, out_valid=0, all outputs 0.
  - A subsequent vector sorts correctly with no residue from the aborted one.
- Back-to-back: hold in_valid=1 and out_ready=1 continuously for 4 random vectors in mixed modes.
  - Accepts occur every 8 cycles.
  - Each result matches a stable reference sort and its inversion count.
